// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and packet types for the instruction-fetch unit
package fetch_pkg;
  localparam int ADDR_W = 12;
  localparam int INSTR_W = 32;
  typedef logic [ADDR_W-1:0] pc_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    pc_t                pc;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: output register plus one-entry skid for fetched packets
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  fetch_pkt_t in_pkt_i,
  output logic       out_valid_o,
  output fetch_pkt_t out_pkt_o,
  input  logic       out_ready_i,
  output logic       skid_valid_o
);
  logic       out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  fetch_pkt_t out_pkt_q, out_pkt_d, skid_pkt_q, skid_pkt_d;
  logic       consume, load_out, to_skid;
  // skid entry is older than a return, so it refills the output first
  always_comb begin
    consume      = out_valid_q && out_ready_i;
    load_out     = in_valid_i && (!out_valid_q || out_ready_i);
    to_skid      = in_valid_i && out_valid_q && !out_ready_i;
    out_valid_d  = flush_i ? 1'b0 : (consume && skid_valid_q) || load_out || (out_valid_q && !consume);
    out_pkt_d    = (consume && skid_valid_q) ? skid_pkt_q : load_out ? in_pkt_i : out_pkt_q;
    skid_valid_d = flush_i ? 1'b0 : to_skid || (skid_valid_q && !consume);
    skid_pkt_d   = to_skid ? in_pkt_i : skid_pkt_q;
  end
  // output and skid registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pkt_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pkt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pkt_q    <= out_pkt_d;
      skid_valid_q <= skid_valid_d;
      skid_pkt_q   <= skid_pkt_d;
    end
  end
  assign out_valid_o  = out_valid_q;
  assign out_pkt_o    = out_pkt_q;
  assign skid_valid_o = skid_valid_q;
endmodule

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: PC register, fetch issue and instruction return toward decode
module fetch_pc_stage #(
  parameter int                 ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                 INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  next_pc_i,
  output logic [ADDR_W-1:0]  pc_plus1_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               if_valid_o,
  input  logic               if_ready_i,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o
);
  import fetch_pkg::*;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic              req_valid_q, issue, out_valid, skid_valid;
  fetch_pkt_t        ret_pkt, out_pkt;
  // a new read is only issued when its return is guaranteed a slot
  always_comb begin
    issue    = !stall_i && !flush_i && !skid_valid && !(req_valid_q && out_valid && !if_ready_i);
    pc_d     = (flush_i || issue) ? next_pc_i : pc_q;
    req_pc_d = issue ? pc_q : req_pc_q;
  end
  // PC and outstanding-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= issue;
      req_pc_q    <= req_pc_d;
    end
  end
  assign pc_plus1_o  = pc_q + ADDR_W'(1);
  assign imem_addr_o = pc_q;
  assign ret_pkt     = '{instr: imem_rdata_i, pc: req_pc_q};
  fetch_skid_buffer u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (req_valid_q),
    .in_pkt_i     (ret_pkt),
    .out_valid_o  (out_valid),
    .out_pkt_o    (out_pkt),
    .out_ready_i  (if_ready_i),
    .skid_valid_o (skid_valid)
  );
  assign if_valid_o = out_valid;
  assign if_instr_o = out_pkt.instr;
  assign if_pc_o    = out_pkt.pc;
endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Program-counter and fetch-pipeline stage of the InstructionFetch unit. Holds the 12-bit PC and issues it to synchronous instruction memory. Also supplies PC+1 to the 2:1 PC-select mux and reloads the PC from that mux's 12-bit result. Pairs each returned instruction with its PC and delivers both to decode through a valid/ready handshake with a one-entry skid buffer, honouring stall and flush.

## Interface
Parameters:
- ADDR_W, 12, PC / instruction-memory address width
- INSTR_W, 32, instruction word width
- RESET_PC, 12'h000, PC value loaded on reset

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- next_pc_i  in  ADDR_W  next PC from the PC-select mux result (PC+1 or zero-extended 8-bit target)
- pc_plus1_o  out  ADDR_W  pc_q + 1 mod 2^ADDR_W, feeds mux data0
- imem_addr_o  out  ADDR_W  instruction-memory address = pc_q
- imem_rdata_i  in  INSTR_W  memory data, valid the cycle after the address
- stall_i  in  1  block new fetch issue
- flush_i  in  1  redirect: kill all in-flight/buffered instructions, load next_pc_i
- if_valid_o  out  1  instruction available to decode
- if_ready_i  in  1  decode accepts this cycle
- if_instr_o  out  INSTR_W  instruction word
- if_pc_o  out  ADDR_W  PC of if_instr_o

## Operation
- State:
  - pc_q
  - req_valid_q / req_pc_q (read outstanding)
  - out_valid_q / out_instr_q / out_pc_q (output register)
  - skid_valid_q / skid_instr_q / skid_pc_q
- issue = !stall_i && !flush_i && !skid_valid_q && !(req_valid_q && out_valid_q && !if_ready_i).
- On issue:
  - req_valid_q<=1
  - req_pc_q<=pc_q
  - pc_q<=next_pc_i
- Otherwise req_valid_q<=0 and pc_q holds, except on flush.
- Return path, when req_valid_q:
  - {imem_rdata_i, req_pc_q} goes to the output register if !out_valid_q or if_ready_i.
  - Otherwise it goes to the skid buffer.
- Consume (out_valid_q && if_ready_i):
  - If skid valid, the skid entry moves into the output register and the skid clears.
  - Otherwise out_valid_q clears, unless a return refills it that same cycle.
- Ordering: the skid entry is always older than the returning data. Returns never bypass a valid skid entry; issue rules make that combination impossible.
- Flush (highest priority, any state):
  - req_valid_q, out_valid_q and skid_valid_q all clear.
  - pc_q<=next_pc_i.
  - The returning word is discarded.
  - if_ready_i is ignored that cycle.
- Stall: no issue. The outstanding return and the skid/output behave normally, so data is never lost.
- Arithmetic: pc_plus1_o wraps 0xFFF -> 0x000 with no carry out. next_pc_i is taken as-is.
- Occupancy is never above 2 (output + skid). Overflow is impossible by construction; the bench asserts this.

## Timing
- Reset values:
  - pc_q = RESET_PC, so imem_addr_o = RESET_PC and pc_plus1_o = RESET_PC+1
  - if_valid_o = 0
  - if_instr_o = 0, if_pc_o = 0
  - all internal valids 0
- Fetch latency:
  - Address issued in cycle N, data arrives in N+1, if_valid_o asserts in N+2.
  - First instruction after reset release: if_valid_o rises on the 2nd edge.
- Throughput: 1 instruction/cycle with if_ready_i held high and no stall.
- Backpressure: when if_ready_i drops, at most one further word lands in the skid.
  - Issue pauses until the skid drains.
  - One bubble on resume is allowed.
- Flush asserted in cycle N:
  - if_valid_o = 0 from N+1.
  - Fetch at the new PC issues in N+1.
  - The new instruction is valid at N+3.
- if_instr_o / if_pc_o stay stable while if_valid_o && !if_ready_i.
- Reset mid-operation clears all state asynchronously. The in-flight word is dropped.

## Structure
- Shared package fetch_pkg:
  - ADDR_W, INSTR_W
  - typedef pc_t (logic [ADDR_W-1:0])
  - struct fetch_pkt_t {instr, pc}
- The PC-select mux and the decode stage both import the same package.
- One sub-module: fetch_skid_buffer, a 1-entry valid/ready skid on fetch_pkt_t with a flush input.
- The top level holds pc_q, the issue logic and the outstanding-request register.

## Test plan
- Reset with RESET_PC=0x000, release, if_ready_i=1, next_pc_i=pc_plus1_o -> if_pc_o sequence 0x000, 0x001, 0x002… from the 2nd edge; if_instr_o = mem[pc].
- PC at 0xFFE, sequential -> if_pc_o 0xFFE, 0xFFF, 0x000; pc_plus1_o at 0xFFF reads 0x000.
- if_ready_i low for 5 cycles mid-stream -> if_valid_o held with stable data, no instruction lost or duplicated, order preserved after release.
- flush_i one cycle with next_pc_i=0x0A5 (8-bit target zero-extended) while output and skid are both full -> if_valid_o low next cycle, next delivered if_pc_o=0x0A5.
- stall_i high for 3 cycles with if_ready_i=1 -> the outstanding word is delivered, then no new issues, pc_q constant; fetch resumes on release.
- rst asserted mid-stream with skid full -> all valids 0 immediately (asynchronous), imem_addr_o=RESET_PC.
